// File: rtl/branch_unit.sv
// branch_unit: resolves B/BL/BX, holds NZCV flags, drives relative PC jumps, link writes and wrong-path squash
module branch_unit #(
  parameter int PC_LEAD = 2,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] instr_addr,
  input  logic [31:0] rm_value,
  input  logic        flag_we,
  input  logic [3:0]  flags_in,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        squash,
  output logic [3:0]  flags
);
  localparam int CW = $clog2(SQUASH_CYCLES + 1);
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] f;
  logic cond_ok, is_b, is_bx, taken;
  logic [31:0] target;
  assign is_b = instr[27:25] == 3'b101;
  assign is_bx = instr[27:4] == 24'h12FFF1;
  // condition code check, with same-cycle flag writes bypassed in
  always_comb begin
    f = flag_we ? flags_in : flags;
    cond_ok = 1'b0;
    case (instr[31:28])
      4'h0: cond_ok = f[2];
      4'h1: cond_ok = !f[2];
      4'h2: cond_ok = f[1];
      4'h3: cond_ok = !f[1];
      4'h4: cond_ok = f[3];
      4'h5: cond_ok = !f[3];
      4'h6: cond_ok = f[0];
      4'h7: cond_ok = !f[0];
      4'h8: cond_ok = f[1] && !f[2];
      4'h9: cond_ok = !f[1] || f[2];
      4'hA: cond_ok = f[3] == f[0];
      4'hB: cond_ok = f[3] != f[0];
      4'hC: cond_ok = !f[2] && (f[3] == f[0]);
      4'hD: cond_ok = f[2] || (f[3] != f[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  assign taken = instr_valid && state == RUN && (is_b || is_bx) && cond_ok;
  assign target = is_bx ? rm_value : instr_addr + 32'd2 + {{8{instr[23]}}, instr[23:0]};
  // squash window sequencing: a taken branch opens the window, cnt counts it down
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == RUN) begin
      state_nx = taken ? SQUASH : RUN;
      cnt_nx = taken ? CW'(SQUASH_CYCLES) : cnt;
    end else begin
      state_nx = cnt == CW'(1) ? RUN : SQUASH;
      cnt_nx = cnt == CW'(1) ? '0 : cnt - CW'(1);
    end
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // registered outputs; offsets and link data hold between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump_en <= 1'b0;
      jump_addr <= '0;
      lr_we <= 1'b0;
      lr_data <= '0;
      squash <= 1'b0;
      flags <= '0;
    end else begin
      jump_en <= taken;
      lr_we <= taken && is_b && instr[24];
      squash <= state_nx == SQUASH;
      if (taken) jump_addr <= target - (instr_addr + 32'(PC_LEAD));
      if (taken && is_b && instr[24]) lr_data <= instr_addr + 32'd1;
      if (flag_we) flags <= flags_in;
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed stimulus, reference model compared every cycle, plus literal spot checks
module tb_branch_unit;
  localparam int PC_LEAD = 2;
  localparam int SQ = 2;
  logic clk = 0, reset = 1, instr_valid = 0, flag_we = 0;
  logic [31:0] instr = 0, instr_addr = 0, rm_value = 0;
  logic [3:0] flags_in = 0;
  logic jump_en, lr_we, squash;
  logic [31:0] jump_addr, lr_data;
  logic [3:0] flags;
  int n_tests = 0, n_fail = 0;
  logic chk_on = 0;

  branch_unit #(.PC_LEAD(PC_LEAD), .SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_addr(instr_addr), .rm_value(rm_value), .flag_we(flag_we),
    .flags_in(flags_in), .jump_en(jump_en), .jump_addr(jump_addr),
    .lr_we(lr_we), .lr_data(lr_data), .squash(squash), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic cond_true(logic [3:0] c, logic [3:0] nzcv);
    logic n, z, cf, v;
    {n, z, cf, v} = nzcv;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic m_jump_en, m_lr_we, m_squash;
  logic [31:0] m_jump_addr, m_lr_data;
  logic [3:0] m_flags;
  int edge_no, sq_end;

  always @(posedge clk or posedge reset) begin
    logic [3:0] fl;
    logic isb, isbx, tk;
    logic [31:0] tgt;
    if (reset) begin
      {m_jump_en, m_lr_we, m_squash} = 0;
      m_jump_addr = 0;
      m_lr_data = 0;
      m_flags = 0;
      edge_no = 0;
      sq_end = 0;
    end else begin
      fl = flag_we ? flags_in : m_flags;
      isb = instr[27:25] == 3'b101;
      isbx = instr[27:4] == 24'h12FFF1;
      tk = instr_valid && edge_no >= sq_end && (isb || isbx) && cond_true(instr[31:28], fl);
      m_jump_en = tk;
      m_lr_we = tk && isb && instr[24];
      if (tk) begin
        tgt = isbx ? rm_value : instr_addr + 2 + {{8{instr[23]}}, instr[23:0]};
        m_jump_addr = tgt - (instr_addr + PC_LEAD);
        sq_end = edge_no + 1 + SQ;
      end
      if (m_lr_we) m_lr_data = instr_addr + 1;
      if (flag_we) m_flags = flags_in;
      m_squash = edge_no + 1 < sq_end;
      edge_no++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("m_jump_en", 32'(jump_en), 32'(m_jump_en));
      check("m_jump_addr", jump_addr, m_jump_addr);
      check("m_lr_we", 32'(lr_we), 32'(m_lr_we));
      check("m_lr_data", lr_data, m_lr_data);
      check("m_squash", 32'(squash), 32'(m_squash));
      check("m_flags", 32'(flags), 32'(m_flags));
    end
  end

  task automatic cyc(logic v, logic [31:0] i, logic [31:0] a, logic [31:0] rm, logic fwe, logic [3:0] fin);
    @(negedge clk);
    instr_valid = v;
    instr = i;
    instr_addr = a;
    rm_value = rm;
    flag_we = fwe;
    flags_in = fin;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(int k);
    repeat (k) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_flags", 32'(flags), 0);
    check("reset_squash", 32'(squash), 0);
    check("reset_jump_en", 32'(jump_en), 0);
    reset = 0;
    chk_on = 1;
    cyc(1, 32'hEA000004, 10, 0, 0, 0);
    check("b_al_jump_en", 32'(jump_en), 1);
    check("b_al_jump_addr", jump_addr, 4);
    check("b_al_squash", 32'(squash), 1);
    check("b_al_lr_we", 32'(lr_we), 0);
    idle(1);
    check("b_al_pulse_end", 32'(jump_en), 0);
    check("b_al_squash2", 32'(squash), 1);
    idle(1);
    check("b_al_squash_end", 32'(squash), 0);
    cyc(1, 32'hEBFFFFFE, 100, 0, 0, 0);
    check("bl_jump_addr", jump_addr, 32'hFFFFFFFE);
    check("bl_lr_we", 32'(lr_we), 1);
    check("bl_lr_data", lr_data, 101);
    idle(2);
    cyc(1, 32'h0A000000, 50, 0, 1, 4'b0100);
    check("beq_bypass_taken", 32'(jump_en), 1);
    check("beq_flags", 32'(flags), 32'h4);
    idle(2);
    cyc(1, 32'h1A000000, 60, 0, 0, 0);
    check("bne_not_taken", 32'(jump_en), 0);
    check("bne_no_squash", 32'(squash), 0);
    cyc(1, 32'h1B000005, 70, 0, 0, 0);
    check("blne_no_lr", 32'(lr_we), 0);
    check("blne_lr_hold", lr_data, 101);
    cyc(1, 32'hFA000004, 80, 0, 0, 0);
    check("never_cond", 32'(jump_en), 0);
    cyc(1, 32'hE12FFF10, 20, 500, 0, 0);
    check("bx_jump_addr", jump_addr, 478);
    check("bx_lr_we", 32'(lr_we), 0);
    idle(2);
    cyc(1, 32'hEA000001, 200, 0, 0, 0);
    check("drop_first", 32'(jump_en), 1);
    cyc(1, 32'hEA000002, 201, 0, 0, 0);
    check("drop_second", 32'(jump_en), 0);
    check("drop_squash_a", 32'(squash), 1);
    cyc(1, 32'hEA000003, 202, 0, 0, 0);
    check("drop_third", 32'(jump_en), 0);
    check("drop_squash_b", 32'(squash), 0);
    check("drop_addr_hold", jump_addr, 1);
    cyc(1, 32'hEA000005, 203, 0, 0, 0);
    check("rerun_taken", 32'(jump_en), 1);
    check("rerun_addr", jump_addr, 5);
    idle(2);
    cyc(0, 0, 0, 0, 1, 4'b1111);
    check("flags_loaded", 32'(flags), 32'hF);
    cyc(1, 32'hEA000000, 300, 0, 0, 0);
    check("pre_reset_squash", 32'(squash), 1);
    @(negedge clk);
    instr_valid = 0;
    reset = 1;
    #1;
    check("mid_reset_squash", 32'(squash), 0);
    check("mid_reset_flags", 32'(flags), 0);
    @(negedge clk);
    reset = 0;
    cyc(1, 32'hEA000007, 400, 0, 0, 0);
    check("post_reset_taken", 32'(jump_en), 1);
    check("post_reset_addr", jump_addr, 7);
    idle(3);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
